// File: rtl/branch_sequencer.sv
// Program-counter sequencer: steps PC, decodes the conditional jump, drives the
// condition unit opcode and loads the latched target when the condition holds.
module branch_sequencer #(
   parameter int unsigned       WIDTH        = 8,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int unsigned       COND_LATENCY = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       instruction,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             cond_result,
   output logic [WIDTH-1:0] pc,
   output logic [2:0]       cond_opcode,
   output logic             busy,
   output logic             jump_taken
);

   // Counter only needs to hold COND_LATENCY-1.
   localparam int unsigned CW = (COND_LATENCY < 2) ? 1 : $clog2(COND_LATENCY);

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      RESOLVE
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    count, count_nx;
   logic [WIDTH-1:0] target, target_nx;
   logic [WIDTH-1:0] pc_nx;
   logic [2:0]       opcode_nx;
   logic             taken_nx;
   logic             is_cjump;

   assign is_cjump = (instruction[7:3] == 5'b11000);
   assign busy     = (state != FETCH);

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      target_nx = target;
      pc_nx     = pc;
      opcode_nx = cond_opcode;
      taken_nx  = 1'b0;
      case (state)
         FETCH: begin
            if (enable) begin
               if (is_cjump) begin
                  opcode_nx = instruction[2:0];
                  target_nx = jump_target;
                  count_nx  = CW'(COND_LATENCY - 1);
                  state_nx  = (COND_LATENCY <= 1) ? RESOLVE : WAIT;
               end else begin
                  pc_nx = pc + 1'b1;
               end
            end
         end
         WAIT: begin
            count_nx = count - 1'b1;
            if (count == CW'(1)) state_nx = RESOLVE;
         end
         RESOLVE: begin
            if (cond_result) begin
               pc_nx    = target;
               taken_nx = 1'b1;
            end else begin
               pc_nx = pc + 1'b1;
            end
            state_nx = FETCH;
         end
         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         count       <= '0;
         target      <= '0;
         pc          <= RESET_VECTOR;
         cond_opcode <= '0;
         jump_taken  <= 1'b0;
      end else begin
         state       <= state_nx;
         count       <= count_nx;
         target      <= target_nx;
         pc          <= pc_nx;
         cond_opcode <= opcode_nx;
         jump_taken  <= taken_nx;
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus randomized
// instruction streams checked against a transaction-level PC model.
module tb_branch_sequencer;

   localparam int unsigned LAT = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] instruction = '0;
   logic [7:0] jump_target = '0;
   logic       cond_result;
   logic [7:0] pc;
   logic [2:0] cond_opcode;
   logic       busy;
   logic       jump_taken;

   logic [7:0] operand = '0;
   logic [7:0] exp_pc;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   branch_sequencer #(
      .WIDTH(8),
      .RESET_VECTOR(8'h00),
      .COND_LATENCY(LAT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .instruction(instruction),
      .jump_target(jump_target),
      .cond_result(cond_result),
      .pc(pc),
      .cond_opcode(cond_opcode),
      .busy(busy),
      .jump_taken(jump_taken)
   );

   always #5 clock = ~clock;

   function automatic logic cond_f(input logic [2:0] op, input logic [7:0] x);
      case (op)
         3'd0: return 1'b0;
         3'd1: return x == 8'd0;
         3'd2: return x != 8'd0;
         3'd3: return x[7];
         3'd4: return 1'b1;
         3'd5: return !x[7] && (x != 8'd0);
         3'd6: return x[0];
         default: return !x[0];
      endcase
   endfunction

   // Registered condition unit stand-in.
   always @(posedge clock) cond_result <= cond_f(cond_opcode, operand);

   // One instruction transaction; noise: 0 hold inputs, 1 target=0x99/enable=0, 2 random.
   task automatic do_instr(input logic [7:0] ins, input logic [7:0] tgt,
                           input logic [7:0] opnd, input int unsigned noise);
      logic       cj;
      logic       tk;
      logic [7:0] dpc;
      cj  = (ins[7:3] == 5'b11000);
      dpc = exp_pc;
      enable = 1'b1; instruction = ins; jump_target = tgt; operand = opnd;
      @(posedge clock); #1;
      if (!cj) begin
         exp_pc = exp_pc + 8'd1;
         n_cmp++;
         if (pc !== exp_pc || busy !== 1'b0 || jump_taken !== 1'b0) begin
            n_err++;
            $display("FAIL step ins=%h: pc=%h busy=%b jt=%b, required pc=%h busy=0 jt=0",
                     ins, pc, busy, jump_taken, exp_pc);
         end
         return;
      end
      n_cmp++;
      if (cond_opcode !== ins[2:0] || busy !== 1'b1 || pc !== dpc || jump_taken !== 1'b0) begin
         n_err++;
         $display("FAIL decode ins=%h: op=%0d busy=%b pc=%h jt=%b, required op=%0d busy=1 pc=%h jt=0",
                  ins, cond_opcode, busy, pc, jump_taken, ins[2:0], dpc);
      end
      for (int unsigned k = 1; k < LAT; k++) begin
         if (noise == 1) begin
            jump_target = 8'h99; enable = 1'b0;
         end else if (noise == 2) begin
            jump_target = 8'($urandom); enable = 1'($urandom); instruction = 8'($urandom);
         end
         @(posedge clock); #1;
         n_cmp++;
         if (busy !== 1'b1 || pc !== dpc || jump_taken !== 1'b0) begin
            n_err++;
            $display("FAIL wait k=%0d: busy=%b pc=%h jt=%b, required busy=1 pc=%h jt=0",
                     k, busy, pc, jump_taken, dpc);
         end
      end
      if (noise == 2) begin
         jump_target = 8'($urandom); enable = 1'($urandom); instruction = 8'($urandom);
      end
      tk = cond_f(ins[2:0], opnd);
      exp_pc = tk ? tgt : dpc + 8'd1;
      @(posedge clock); #1;
      n_cmp++;
      if (pc !== exp_pc || jump_taken !== tk || busy !== 1'b0 || cond_opcode !== ins[2:0]) begin
         n_err++;
         $display("FAIL resolve ins=%h opnd=%h: pc=%h jt=%b busy=%b op=%0d, required pc=%h jt=%b busy=0 op=%0d",
                  ins, opnd, pc, jump_taken, busy, cond_opcode, exp_pc, tk, ins[2:0]);
      end
      enable = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if (pc !== 8'h00 || cond_opcode !== 3'd0 || busy !== 1'b0 || jump_taken !== 1'b0) begin
         n_err++;
         $display("FAIL reset: pc=%h op=%0d busy=%b jt=%b, required 00/0/0/0",
                  pc, cond_opcode, busy, jump_taken);
      end
      reset = 1'b0;
      exp_pc = 8'h00;
      for (int i = 0; i < 3; i++) do_instr(8'h00, 8'h00, 8'h00, 0);
   endtask

   task automatic test_hold();
      logic [7:0] p;
      p = exp_pc;
      enable = 1'b0; instruction = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (pc !== p || busy !== 1'b0 || jump_taken !== 1'b0) begin
            n_err++;
            $display("FAIL hold i=%0d: pc=%h busy=%b jt=%b, required pc=%h busy=0 jt=0",
                     i, pc, busy, jump_taken, p);
         end
      end
   endtask

   task automatic test_jump_taken();
      while (exp_pc != 8'h10) do_instr(8'h00, 8'h00, 8'h00, 0);
      do_instr(8'hC4, 8'h40, 8'h00, 0);
      test_hold();
   endtask

   task automatic test_not_taken();
      do_instr(8'hC1, 8'h77, 8'h05, 0);
   endtask

   task automatic test_wrap();
      do_instr(8'hC4, 8'hFF, 8'h00, 0);
      do_instr(8'hC0, 8'h12, 8'h00, 0);
      do_instr(8'hC4, 8'hFF, 8'h00, 0);
      do_instr(8'h07, 8'h00, 8'h00, 0);
   endtask

   task automatic test_wait_inputs_ignored();
      do_instr(8'hC4, 8'h40, 8'h00, 1);
      do_instr(8'hC6, 8'h33, 8'h01, 2);
   endtask

   task automatic test_reset_mid_wait();
      enable = 1'b1; instruction = 8'hC4; jump_target = 8'h55;
      @(posedge clock); #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (pc !== 8'h00 || cond_opcode !== 3'd0 || busy !== 1'b0 || jump_taken !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: pc=%h op=%0d busy=%b jt=%b, required 00/0/0/0",
                  pc, cond_opcode, busy, jump_taken);
      end
      enable = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_pc = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (pc !== 8'h00 || busy !== 1'b0 || jump_taken !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset i=%0d: pc=%h busy=%b jt=%b, required 00/0/0",
                     i, pc, busy, jump_taken);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ins;
      for (int i = 0; i < 200; i++) begin
         ins = ($urandom_range(1) == 1) ? {5'b11000, 3'($urandom)} : 8'($urandom);
         do_instr(ins, 8'($urandom), 8'($urandom), 2);
         if ($urandom_range(3) == 0) test_hold();
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_jump_taken();
      test_not_taken();
      test_wrap();
      test_wait_inputs_ignored();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
